load_store_queue: RTL
=====================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter NUM_PHYS_REGS, default 64: physical register count; TAG_W = clog2(NUM_PHYS_REGS).
REQ-002 SHALL have parameter ADDR_W, default 32: memory address width.
REQ-003 SHALL have parameter DEPTH, default 16: entry count; power of two, >= 2; PTR_W = clog2(DEPTH).
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 FLUSH  in  1  synchronous clear of all entries.
REQ-007 ENQ_VALID  in  1  enqueue request.
REQ-008 ENQ_READY  out  1  queue can accept an entry (= !FULL).
REQ-009 ENQ_IS_STORE  in  1  0 = load, 1 = store.
REQ-010 ENQ_ADDR_VLD  in  1  address known at enqueue.
REQ-011 ENQ_TAG  in  TAG_W  physical register tag.
REQ-012 ENQ_ADDR  in  ADDR_W  memory address.
REQ-013 UPD_VALID  in  1  address-update request.
REQ-014 UPD_IS_STORE, UPD_TAG, UPD_ADDR  in  1/TAG_W/ADDR_W  update key and new address.
REQ-015 UPD_HIT  out  1  registered; update matched an entry last cycle.
REQ-016 DEQ_REQ  in  1  pop head request.
REQ-017 DEQ_VALID  out  1  head entry present and address valid.
REQ-018 DEQ_IS_STORE, DEQ_TAG, DEQ_ADDR  out  1/TAG_W/ADDR_W  head entry fields, combinational from head.
REQ-019 FULL, EMPTY  out  1  occupancy flags.
REQ-020 COUNT  out  PTR_W+1  occupancy, 0..DEPTH.

Function
REQ-021 Entries SHALL be kept in age order in a circular buffer: head = oldest, tail = next free slot; both wrap from DEPTH-1 to 0.
REQ-022 Enqueue SHALL occur when ENQ_VALID && ENQ_READY; the entry is written at tail with valid=1, addr_vld=ENQ_ADDR_VLD.
REQ-023 Dequeue SHALL occur when DEQ_REQ && DEQ_VALID; head entry valid cleared, head advances; DEQ_REQ while !DEQ_VALID SHALL be ignored.
REQ-024 Simultaneous enqueue and dequeue SHALL both complete; COUNT unchanged; ENQ_READY evaluates pre-dequeue occupancy, so a full queue does not accept.
REQ-025 Update SHALL search valid entries for (is_store, tag) == (UPD_IS_STORE, UPD_TAG), choose the oldest match, write UPD_ADDR, set addr_vld=1 and UPD_HIT=1 next cycle; no match SHALL leave entries unchanged and UPD_HIT=0.
REQ-026 An update and a dequeue of the same entry in one cycle SHALL apply the dequeue only; an update SHALL NOT match the entry being enqueued that cycle.
REQ-027 FULL = (COUNT == DEPTH); EMPTY = (COUNT == 0); DEQ_VALID = 0 when EMPTY.
REQ-028 FLUSH SHALL, next edge, clear all valid bits, head, tail, COUNT and UPD_HIT; FLUSH overrides same-cycle enqueue, dequeue and update.

Reset
REQ-029 RESET low SHALL immediately clear head, tail, COUNT, all valid/addr_vld bits and UPD_HIT; outputs: FULL=0, EMPTY=1, ENQ_READY=1, DEQ_VALID=0, COUNT=0.
REQ-030 Entry payload storage SHALL NOT require reset; outputs SHALL be independent of unreset payload when EMPTY.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first edge after release SHALL behave as on an empty queue.

Configuration
REQ-032 Macro LSQ_STORE_FWD_EN SHALL, when defined, add ports FWD_ADDR (in, ADDR_W), FWD_HIT (out, 1), FWD_TAG (out, TAG_W): combinational search for the youngest valid, addr_vld store with address == FWD_ADDR; FWD_HIT=1 and FWD_TAG=its tag on match, else FWD_HIT=0, FWD_TAG=0.
REQ-033 Without LSQ_STORE_FWD_EN the forwarding ports and search logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, enqueue 16 loads (tags 0..15, addr_vld=1) -> FULL=1, COUNT=16, ENQ_READY=0; 17th ENQ_VALID ignored.
REQ-035 Full queue, ENQ_VALID and DEQ_REQ same cycle -> dequeue tag 0 only, COUNT=15, then enqueue accepted next cycle; tail wraps to 0.
REQ-036 Enqueue store tag 5 addr_vld=0 -> DEQ_VALID=0; UPD store tag 5 addr 0x1000 -> UPD_HIT=1, DEQ_VALID=1, DEQ_ADDR=0x1000.
REQ-037 Update load tag 9 with no such entry -> UPD_HIT=0, queue contents unchanged.
REQ-038 With LSQ_STORE_FWD_EN: stores tag 3 then tag 7, both addr 0x40 -> FWD_ADDR=0x40 gives FWD_HIT=1, FWD_TAG=7; FWD_ADDR=0x44 gives FWD_HIT=0.
REQ-039 FLUSH with 5 entries plus concurrent ENQ_VALID -> COUNT=0, EMPTY=1 next cycle; RESET low mid-burst -> EMPTY=1 immediately.

Source files
------------

// File: rtl/load_store_queue.sv
// Age-ordered load/store queue: circular buffer with in-place address updates.
// Define LSQ_STORE_FWD_EN to add the combinational store-to-load forwarding search.
module load_store_queue #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int ADDR_W        = 32,
    parameter int DEPTH         = 16,
    localparam int TAG_W        = $clog2(NUM_PHYS_REGS),
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              ENQ_VALID,
    output logic              ENQ_READY,
    input  logic              ENQ_IS_STORE,
    input  logic              ENQ_ADDR_VLD,
    input  logic [TAG_W-1:0]  ENQ_TAG,
    input  logic [ADDR_W-1:0] ENQ_ADDR,
    input  logic              UPD_VALID,
    input  logic              UPD_IS_STORE,
    input  logic [TAG_W-1:0]  UPD_TAG,
    input  logic [ADDR_W-1:0] UPD_ADDR,
    output logic              UPD_HIT,
    input  logic              DEQ_REQ,
    output logic              DEQ_VALID,
    output logic              DEQ_IS_STORE,
    output logic [TAG_W-1:0]  DEQ_TAG,
    output logic [ADDR_W-1:0] DEQ_ADDR,
    output logic              FULL,
    output logic              EMPTY,
`ifdef LSQ_STORE_FWD_EN
    input  logic [ADDR_W-1:0] FWD_ADDR,
    output logic              FWD_HIT,
    output logic [TAG_W-1:0]  FWD_TAG,
`endif
    output logic [PTR_W:0]    COUNT
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              upd_hit_q, upd_hit_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  addr_vld_q, addr_vld_d;

    logic              is_store_q [DEPTH];
    logic              is_store_d [DEPTH];
    logic [TAG_W-1:0]  tag_q      [DEPTH];
    logic [TAG_W-1:0]  tag_d      [DEPTH];
    logic [ADDR_W-1:0] addr_q     [DEPTH];
    logic [ADDR_W-1:0] addr_d     [DEPTH];

    logic              enq_fire;
    logic              deq_fire;
    logic              upd_found;
    logic              upd_apply;
    logic [PTR_W-1:0]  upd_idx;
    logic [PTR_W-1:0]  upd_scan_idx;

    assign FULL      = (count_q == (PTR_W+1)'(DEPTH));
    assign EMPTY     = (count_q == '0);
    assign ENQ_READY = !FULL;
    assign COUNT     = count_q;
    assign UPD_HIT   = upd_hit_q;

    // Head slot is valid exactly when the queue is non-empty, so gating on it
    // keeps unreset payload off the outputs.
    assign DEQ_VALID    = valid_q[head_q] && addr_vld_q[head_q];
    assign DEQ_IS_STORE = valid_q[head_q] ? is_store_q[head_q] : 1'b0;
    assign DEQ_TAG      = valid_q[head_q] ? tag_q[head_q]      : '0;
    assign DEQ_ADDR     = valid_q[head_q] ? addr_q[head_q]     : '0;

    assign enq_fire = ENQ_VALID && ENQ_READY;
    assign deq_fire = DEQ_REQ && DEQ_VALID;

    // Scan from head so the first hit is the oldest matching entry.
    always_comb begin
        upd_found    = 1'b0;
        upd_idx      = head_q;
        upd_scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            upd_scan_idx = head_q + PTR_W'(i);
            if (!upd_found && valid_q[upd_scan_idx]
                && (is_store_q[upd_scan_idx] == UPD_IS_STORE)
                && (tag_q[upd_scan_idx] == UPD_TAG)) begin
                upd_found = 1'b1;
                upd_idx   = upd_scan_idx;
            end
        end
    end

    // An update that lands on the entry leaving this cycle is dropped.
    assign upd_apply = UPD_VALID && upd_found && !(deq_fire && (upd_idx == head_q));

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        upd_hit_d  = 1'b0;
        valid_d    = valid_q;
        addr_vld_d = addr_vld_q;
        is_store_d = is_store_q;
        tag_d      = tag_q;
        addr_d     = addr_q;

        if (FLUSH) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            valid_d    = '0;
            addr_vld_d = '0;
        end else begin
            if (upd_apply) begin
                addr_d[upd_idx]     = UPD_ADDR;
                addr_vld_d[upd_idx] = 1'b1;
                upd_hit_d           = 1'b1;
            end
            if (deq_fire) begin
                valid_d[head_q]    = 1'b0;
                addr_vld_d[head_q] = 1'b0;
                head_d             = head_q + PTR_W'(1);
            end
            // The tail slot is never valid while not full, so no update can target it.
            if (enq_fire) begin
                valid_d[tail_q]    = 1'b1;
                addr_vld_d[tail_q] = ENQ_ADDR_VLD;
                is_store_d[tail_q] = ENQ_IS_STORE;
                tag_d[tail_q]      = ENQ_TAG;
                addr_d[tail_q]     = ENQ_ADDR;
                tail_d             = tail_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(deq_fire);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            upd_hit_q  <= 1'b0;
            valid_q    <= '0;
            addr_vld_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            upd_hit_q  <= upd_hit_d;
            valid_q    <= valid_d;
            addr_vld_q <= addr_vld_d;
        end
    end

    always_ff @(posedge CLK) begin
        is_store_q <= is_store_d;
        tag_q      <= tag_d;
        addr_q     <= addr_d;
    end

`ifdef LSQ_STORE_FWD_EN
    logic [PTR_W-1:0] fwd_scan_idx;

    // Later hits overwrite earlier ones, leaving the youngest matching store.
    always_comb begin
        FWD_HIT      = 1'b0;
        FWD_TAG      = '0;
        fwd_scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_scan_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_scan_idx] && addr_vld_q[fwd_scan_idx]
                && is_store_q[fwd_scan_idx]
                && (addr_q[fwd_scan_idx] == FWD_ADDR)) begin
                FWD_HIT = 1'b1;
                FWD_TAG = tag_q[fwd_scan_idx];
            end
        end
    end
`endif

endmodule
